// File: rtl/flash_pkg.sv
// Shared encodings and helpers for the flash value reader: operand modes,
// fixed sizes, FSM states and LEB128 shift arithmetic.
package flash_pkg;

    localparam int LEB_MAX_BYTES = 5;

    typedef enum logic [1:0] {
        MODE_FIX_U = 2'b00,
        MODE_FIX_S = 2'b01,
        MODE_LEB_U = 2'b10,
        MODE_LEB_S = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SIZE_1B     = 2'd0,
        SIZE_2B     = 2'd1,
        SIZE_4B     = 2'd2,
        SIZE_4B_ALT = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_QUIET,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RELEASE,
        ST_RESP
    } state_e;

    // Index of the last byte of a fixed-width operand; size 3 aliases 4 bytes.
    function automatic logic [2:0] fixed_last_idx(input size_e s);
        case (s)
            SIZE_1B: return 3'd0;
            SIZE_2B: return 3'd1;
            default: return 3'd3;
        endcase
    endfunction

    // 7*idx, saturating at the fifth byte's position.
    function automatic logic [4:0] leb_shift(input logic [2:0] idx);
        case (idx)
            3'd0:    return 5'd0;
            3'd1:    return 5'd7;
            3'd2:    return 5'd14;
            3'd3:    return 5'd21;
            default: return 5'd28;
        endcase
    endfunction

endpackage

// File: rtl/flash_value_reader_if.sv
// Request/response handshake between the fetch logic (master) and the
// flash value reader (slave).
interface flash_value_reader_if #(
    parameter int ADDR_W = 24
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_mode;
    logic [1:0]        req_size;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [2:0]        rsp_len;
    logic [ADDR_W-1:0] rsp_next_addr;
    logic              rsp_error;

    modport master (
        output req_valid, req_addr, req_mode, req_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_len, rsp_next_addr, rsp_error
    );

    modport slave (
        input  req_valid, req_addr, req_mode, req_size, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_len, rsp_next_addr, rsp_error
    );
endinterface

// File: rtl/value_assembler.sv
// Byte index and accumulator; decodes the operand value as each byte arrives
// so the FSM can register the final result on the capture cycle.
module value_assembler
    import flash_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        capture_i,
    input  logic [7:0]  byte_i,
    input  mode_e       mode_i,
    input  size_e       size_i,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] value_o,
    output logic [2:0]  len_o
);

    logic [31:0] acc_q, acc_d;
    logic [2:0]  idx_q, idx_d;
    logic        is_leb, is_signed;
    logic [31:0] fix_part, leb_part;
    logic [4:0]  leb_sh, leb_sh_next;

    always_comb begin
        is_leb      = (mode_i == MODE_LEB_U) || (mode_i == MODE_LEB_S);
        is_signed   = (mode_i == MODE_FIX_S) || (mode_i == MODE_LEB_S);
        fix_part    = {24'd0, byte_i} << {idx_q[1:0], 3'b000};
        leb_sh      = leb_shift(idx_q);
        leb_sh_next = leb_shift(idx_q + 3'd1);
        // Bits shifted past 31 on the fifth LEB byte fall off here.
        leb_part    = {25'd0, byte_i[6:0]} << leb_sh;
        acc_d       = acc_q | (is_leb ? leb_part : fix_part);
        idx_d       = idx_q + 3'd1;
        len_o       = idx_d;
        error_o     = 1'b0;
        value_o     = acc_d;
        if (is_leb) begin
            done_o  = !byte_i[7] || (idx_q == 3'(LEB_MAX_BYTES - 1));
            error_o = byte_i[7] && (idx_q == 3'(LEB_MAX_BYTES - 1));
            if (error_o)
                value_o = '0;
            else if (is_signed && byte_i[6] && (idx_q < 3'(LEB_MAX_BYTES - 1)))
                value_o = acc_d | (32'hFFFF_FFFF << leb_sh_next);
        end else begin
            done_o = (idx_q == fixed_last_idx(size_i));
            if (is_signed && (size_i == SIZE_1B) && acc_d[7])
                value_o[31:8] = '1;
            else if (is_signed && (size_i == SIZE_2B) && acc_d[15])
                value_o[31:16] = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            acc_q <= '0;
            idx_q <= '0;
        end else if (capture_i) begin
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/flash_value_reader.sv
// Reads a fixed-width or LEB128 operand from the SPI flash byte reader one
// byte at a time and returns the decoded value, length and next address.
module flash_value_reader
    import flash_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int RESET_QUIET = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    flash_value_reader_if.slave  bus,
    output logic [ADDR_W-1:0]    flash_addr,
    output logic                 flash_enable,
    input  logic [7:0]           flash_byte,
    input  logic                 flash_data_ready
);

    localparam int QW = $clog2(RESET_QUIET + 1);

    state_e            state_q;
    logic [QW-1:0]     quiet_q;
    logic [ADDR_W-1:0] addr_q;
    mode_e             mode_q;
    size_e             size_q;
    logic              req_ready_q, rsp_valid_q, rsp_error_q, fen_q;
    logic [31:0]       rsp_data_q;
    logic [2:0]        rsp_len_q;
    logic [ADDR_W-1:0] rsp_next_q, faddr_q;

    logic        cap, clr, asm_done, asm_error;
    logic [31:0] asm_value;
    logic [2:0]  asm_len;

    // Data-ready is only honoured in WAIT; in ISSUE it is still the stale flag.
    assign cap = (state_q == ST_WAIT) && flash_data_ready;
    assign clr = (state_q == ST_IDLE) && bus.req_valid;

    value_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (clr),
        .capture_i (cap),
        .byte_i    (flash_byte),
        .mode_i    (mode_q),
        .size_i    (size_q),
        .done_o    (asm_done),
        .error_o   (asm_error),
        .value_o   (asm_value),
        .len_o     (asm_len)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_QUIET;
            quiet_q     <= '0;
            addr_q      <= '0;
            mode_q      <= MODE_FIX_U;
            size_q      <= SIZE_1B;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_len_q   <= '0;
            rsp_next_q  <= '0;
            rsp_error_q <= 1'b0;
            fen_q       <= 1'b0;
            faddr_q     <= '0;
        end else begin
            unique case (state_q)
                ST_QUIET: begin
                    if (quiet_q == QW'(RESET_QUIET - 1)) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end else begin
                        quiet_q <= quiet_q + QW'(1);
                    end
                end
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        mode_q      <= mode_e'(bus.req_mode);
                        size_q      <= size_e'(bus.req_size);
                        req_ready_q <= 1'b0;
                        fen_q       <= 1'b1;
                        faddr_q     <= bus.req_addr;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (cap) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        fen_q  <= 1'b0;
                        if (asm_done) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= asm_value;
                            rsp_len_q   <= asm_len;
                            rsp_error_q <= asm_error;
                            rsp_next_q  <= addr_q + ADDR_W'(1);
                            state_q     <= ST_RESP;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    fen_q   <= 1'b1;
                    faddr_q <= addr_q;
                    state_q <= ST_ISSUE;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_QUIET;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_len       = rsp_len_q;
    assign bus.rsp_next_addr = rsp_next_q;
    assign bus.rsp_error     = rsp_error_q;
    assign flash_enable      = fen_q;
    assign flash_addr        = faddr_q;

endmodule

// File: tb/tb_flash_value_reader.sv
// Directed bench for flash_value_reader with a behavioural byte reader that
// keeps dataReady stale high until it sees enable again.
module tb_flash_value_reader;

    localparam int T_F = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] flash_addr;
    logic        flash_enable;
    logic [7:0]  flash_byte = 8'hAA;
    logic        flash_data_ready = 1'b1;

    flash_value_reader_if #(.ADDR_W(24)) bus ();

    flash_value_reader #(.ADDR_W(24), .RESET_QUIET(128)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .flash_addr       (flash_addr),
        .flash_enable     (flash_enable),
        .flash_byte       (flash_byte),
        .flash_data_ready (flash_data_ready)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [bit [23:0]];
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    int          pulses = 0;
    logic [23:0] m_addr = '0;
    logic [23:0] a_last = '0;
    logic [23:0] a_prev = '0;

    always @(posedge clk) begin
        if (!flash_enable) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            m_busy           <= 1'b1;
            m_cnt            <= T_F;
            flash_data_ready <= 1'b0;
            m_addr           <= flash_addr;
            a_last           <= flash_addr;
            a_prev           <= a_last;
            pulses           <= pulses + 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                flash_data_ready <= 1'b1;
                flash_byte       <= mem[m_addr];
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " quiet cycles"}, n, 128);
    endtask

    task automatic issue(input logic [23:0] a, input logic [1:0] m, input logic [1:0] s);
        int n = 0;
        while (!bus.req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("req_ready timeout", 0, 1);
        bus.req_addr  = a;
        bus.req_mode  = m;
        bus.req_size  = s;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic accept(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, " rsp_valid after accept"}, {31'd0, bus.rsp_valid}, 0);
        check({tag, " req_ready after accept"}, {31'd0, bus.req_ready}, 1);
    endtask

    task automatic rd(input string tag, input logic [23:0] a, input logic [1:0] m,
                      input logic [1:0] s, input logic [31:0] exp_data, input logic [2:0] exp_len,
                      input logic [23:0] exp_next, input logic exp_err, input int exp_pulses,
                      input int hold);
        int p0 = pulses;
        int n = 0;
        issue(a, m, s);
        @(negedge clk);
        while (!bus.rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " rsp_valid"}, {31'd0, bus.rsp_valid}, 1);
        check({tag, " rsp_data"}, bus.rsp_data, exp_data);
        check({tag, " rsp_len"}, {29'd0, bus.rsp_len}, {29'd0, exp_len});
        check({tag, " rsp_next_addr"}, {8'd0, bus.rsp_next_addr}, {8'd0, exp_next});
        check({tag, " rsp_error"}, {31'd0, bus.rsp_error}, {31'd0, exp_err});
        check({tag, " req_ready in RESP"}, {31'd0, bus.req_ready}, 0);
        check({tag, " enable pulses"}, pulses - p0, exp_pulses);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold data"}, bus.rsp_data, exp_data);
            check({tag, " hold state"},
                  {22'd0, bus.rsp_valid, bus.req_ready, flash_enable, bus.rsp_error, 3'd0, bus.rsp_len},
                  {22'd0, 1'b1, 1'b0, 1'b0, exp_err, 3'd0, exp_len});
        end
        accept(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_mode  = '0;
        bus.req_size  = '0;
        bus.rsp_ready = 1'b0;
        mem[24'h000100] = 8'h78; mem[24'h000101] = 8'h56;
        mem[24'h000102] = 8'h34; mem[24'h000103] = 8'h12;
        mem[24'h000200] = 8'h80;
        mem[24'h000210] = 8'h00; mem[24'h000211] = 8'h80;
        mem[24'h000300] = 8'hE5; mem[24'h000301] = 8'h8E; mem[24'h000302] = 8'h26;
        mem[24'h000310] = 8'hC0; mem[24'h000311] = 8'hBB; mem[24'h000312] = 8'h78;
        for (int i = 0; i < 5; i++) mem[24'h000320 + 24'(i)] = 8'h80;
        mem[24'h000330] = 8'h7F;
        for (int i = 0; i < 4; i++) mem[24'h000340 + 24'(i)] = 8'hFF;
        mem[24'h000344] = 8'h0F;
        mem[24'hFFFFFF] = 8'h34; mem[24'h000000] = 8'h12;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", {31'd0, bus.req_ready}, 0);
        check("reset rsp_valid", {31'd0, bus.rsp_valid}, 0);
        check("reset rsp_data", bus.rsp_data, 0);
        check("reset rsp_len", {29'd0, bus.rsp_len}, 0);
        check("reset rsp_next_addr", {8'd0, bus.rsp_next_addr}, 0);
        check("reset rsp_error", {31'd0, bus.rsp_error}, 0);
        check("reset flash_enable", {31'd0, flash_enable}, 0);
        check("reset flash_addr", {8'd0, flash_addr}, 0);
        reset = 1'b0;
        wait_quiet("por");

        rd("fix_u4", 24'h000100, 2'b00, 2'd2, 32'h12345678, 3'd4, 24'h000104, 1'b0, 4, 0);
        rd("fix_s1", 24'h000200, 2'b01, 2'd0, 32'hFFFFFF80, 3'd1, 24'h000201, 1'b0, 1, 0);
        rd("fix_s2", 24'h000210, 2'b01, 2'd1, 32'hFFFF8000, 3'd2, 24'h000212, 1'b0, 2, 0);
        rd("fix_u2_hold", 24'h000210, 2'b00, 2'd1, 32'h00008000, 3'd2, 24'h000212, 1'b0, 2, 10);
        rd("fix_u3as4", 24'h000100, 2'b00, 2'd3, 32'h12345678, 3'd4, 24'h000104, 1'b0, 4, 0);
        rd("leb_u", 24'h000300, 2'b10, 2'd0, 32'd624485, 3'd3, 24'h000303, 1'b0, 3, 0);
        rd("leb_s", 24'h000310, 2'b11, 2'd0, 32'hFFFE1DC0, 3'd3, 24'h000313, 1'b0, 3, 0);
        rd("leb_over", 24'h000320, 2'b10, 2'd0, 32'h00000000, 3'd5, 24'h000325, 1'b1, 5, 0);
        rd("leb_s1", 24'h000330, 2'b11, 2'd0, 32'hFFFFFFFF, 3'd1, 24'h000331, 1'b0, 1, 0);
        rd("leb_u5", 24'h000340, 2'b10, 2'd0, 32'hFFFFFFFF, 3'd5, 24'h000345, 1'b0, 5, 0);
        rd("wrap", 24'hFFFFFF, 2'b00, 2'd1, 32'h00001234, 3'd2, 24'h000001, 1'b0, 2, 0);
        check("wrap first addr", {8'd0, a_prev}, 32'h00FFFFFF);
        check("wrap second addr", {8'd0, a_last}, 32'h00000000);

        issue(24'h000100, 2'b00, 2'd2);
        @(negedge clk);
        check("mid issue enable", {31'd0, flash_enable}, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset enable", {31'd0, flash_enable}, 0);
        check("mid reset req_ready", {31'd0, bus.req_ready}, 0);
        check("mid reset rsp_valid", {31'd0, bus.rsp_valid}, 0);
        reset = 1'b0;
        wait_quiet("mid");
        rd("after_reset", 24'h000300, 2'b10, 2'd0, 32'd624485, 3'd3, 24'h000303, 1'b0, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flash_value_reader.md
# flash_value_reader

Value-level front end for the SPI flash byte reader. It accepts a request for one operand at a 24-bit flash address: fixed-width little-endian 1/2/4 bytes, or a WebAssembly LEB128 u32/s32. It drives the byte reader's `addr`/`enable` handshake once per byte and returns a 32-bit value, the bytes consumed and the next address. It sits between the CPU's bytecode/immediate fetch logic and the flash byte reader.

## Interface
- `ADDR_W`, 24: flash byte address width.
- `RESET_QUIET`, 128: cycles after reset before the first request is accepted. Must exceed one full flash byte read.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and able to accept.
- `req_addr` in ADDR_W: first byte address.
- `req_mode` in 2:
  - 00: fixed unsigned.
  - 01: fixed signed.
  - 10: LEB unsigned.
  - 11: LEB signed.
- `req_size` in 2: fixed modes only. 0=1B, 1=2B, 2=4B, 3 treated as 4B.
- `rsp_valid` out 1: response held until accepted.
- `rsp_ready` in 1: consumer accepts.
- `rsp_data` out 32: decoded value.
- `rsp_len` out 3: bytes consumed (1..5).
- `rsp_next_addr` out ADDR_W: `req_addr + rsp_len`, modulo 2^ADDR_W.
- `rsp_error` out 1: LEB overlong (continuation bit set on the 5th byte).
- `flash_addr` out ADDR_W: to byte reader `addr`.
- `flash_enable` out 1: to byte reader `enable`.
- `flash_byte` in 8: from byte reader `byteRead`.
- `flash_data_ready` in 1: from byte reader `dataReady`.

## Operation
- States: QUIET, IDLE, ISSUE, WAIT, RELEASE, RESP.
- QUIET: entered on reset; counts RESET_QUIET cycles, then goes to IDLE. `req_ready`=0 during QUIET.
- IDLE: `req_ready`=1. On `req_valid`:
  - latch addr, mode and size;
  - clear the accumulator, byte index and error;
  - go to ISSUE.
- ISSUE (1 cycle): `flash_enable`=1, `flash_addr`=current address. `flash_data_ready` is ignored here, because the byte reader holds it stale high until it sees `enable`. Next state is WAIT.
- WAIT: `flash_enable`=1. On `flash_data_ready`=1:
  - capture `flash_byte` into the accumulator at index i;
  - increment i and the address;
  - if more bytes are needed, go to RELEASE; otherwise go to RESP.
- RELEASE (1 cycle): `flash_enable`=0, which lets the byte reader leave DONE. Next state is ISSUE.
- RESP: `rsp_valid`=1 and all rsp_* stable. On `rsp_ready`, go to IDLE.
- Fixed modes:
  - byte i is placed at `rsp_data[8i+7:8i]`;
  - signed mode sign-extends from bit 8·size−1;
  - unsigned mode zero-fills.
- LEB modes:
  - `acc |= (byte & 0x7F) << 7i`; continue while bit 7 is set;
  - the final byte at i≤4 terminates; high bits of the 5th byte beyond bit 31 are discarded;
  - signed mode: if the final byte has bit 6 set and 7(i+1)<32, set bits [31:7(i+1)];
  - overlong (5th byte has bit 7 set): stop reading, go to RESP with `rsp_error`=1, `rsp_data`=0, `rsp_len`=5.
- Address arithmetic wraps at 2^ADDR_W, including `rsp_next_addr`.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_len`=0, `rsp_next_addr`=0, `rsp_error`=0, `flash_enable`=0, `flash_addr`=0.
- All outputs are registered.
- Per byte: 1 ISSUE cycle + T_f (byte reader latency) + 1 RELEASE cycle (omitted after the last byte).
- `rsp_valid` rises on the cycle after the final capture.
- `req_ready` and `rsp_valid` are never high together. `req_valid` is ignored outside IDLE.
- `rsp_valid` held with `rsp_ready`=0: all outputs hold indefinitely.
- Reset mid-read:
  - `flash_enable` drops on the next cycle;
  - QUIET lets the byte reader complete and return to idle before any reuse.

## Structure
- Shared package `flash_pkg`: mode encodings, size encodings, `LEB_MAX_BYTES`=5, and the state enum.
- Sub-module `value_assembler`: byte index + accumulator + mode/size logic → `done`, `data`, `error`. The top level keeps the FSM and flash handshake.

## Test plan
- Fixed unsigned 4B at 0x000100, flash bytes 78 56 34 12 → `rsp_data`=0x12345678, `rsp_len`=4, `rsp_next_addr`=0x000104, 4 enable pulses.
- Fixed signed 1B, byte 0x80 → `rsp_data`=0xFFFFFF80; fixed signed 2B, bytes 00 80 → 0xFFFF8000.
- LEB unsigned E5 8E 26 → 624485, `rsp_len`=3.
- LEB signed C0 BB 78 → −123456 (0xFFFE1DC0).
- LEB 80 80 80 80 80 → `rsp_error`=1, `rsp_len`=5.
- Wrap and handshake:
  - 2B at 0xFFFFFF → bytes read from 0xFFFFFF then 0x000000, `rsp_next_addr`=0x000001;
  - stale `flash_data_ready`=1 during ISSUE is not captured;
  - `rsp_ready` held low 10 cycles leaves outputs unchanged;
  - reset during WAIT → `flash_enable`=0 next cycle, `req_ready`=0 for 128 cycles.
